// File: rtl/apb_timer_multi.sv
// apb_timer_multi: N_CH independent compare/interrupt up-counters behind one APB slave.
// Define APB_TIMER_PRESCALER_EN to build the per-channel 8-bit prescaler (PSC_EN/PSC fields).
module apb_timer_multi #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int N_CH           = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR_i,
    input  logic [31:0]               PWDATA_i,
    input  logic                      PWRITE_i,
    input  logic                      PSEL_i,
    input  logic                      PENABLE_i,
    output logic [31:0]               PRDATA_o,
    output logic                      PREADY_o,
    output logic                      PSLVERR_o,
    input  logic [N_CH-1:0]           event_i,
    output logic [N_CH-1:0]           irq_o
);

    logic [3:0]      ch_sel;
    logic [1:0]      reg_sel;
    logic            access, ch_ok, wr;
    logic [N_CH-1:0] wr_ch, tick, match;
    logic            unused_bits;

    logic [N_CH-1:0] en_q, en_d, irq_en_q, irq_en_d, cmp_clr_q, cmp_clr_d;
    logic [N_CH-1:0] one_shot_q, one_shot_d, pend_q, pend_d, irq_q;
    logic [CNT_WIDTH-1:0] val_q [N_CH];
    logic [CNT_WIDTH-1:0] val_d [N_CH];
    logic [CNT_WIDTH-1:0] cmp_q [N_CH];
    logic [CNT_WIDTH-1:0] cmp_d [N_CH];
`ifdef APB_TIMER_PRESCALER_EN
    logic [N_CH-1:0] psc_en_q, psc_en_d;
    logic [7:0]      psc_q  [N_CH];
    logic [7:0]      psc_d  [N_CH];
    logic [7:0]      pcnt_q [N_CH];
    logic [7:0]      pcnt_d [N_CH];
`endif

    assign ch_sel      = PADDR_i[7:4];
    assign reg_sel     = PADDR_i[3:2];
    assign access      = PSEL_i & PENABLE_i;
    assign ch_ok       = (32'(ch_sel) < 32'(N_CH));
    assign wr          = access & PWRITE_i & ch_ok;
    assign PREADY_o    = 1'b1;
    assign PSLVERR_o   = access & ~ch_ok;
    assign irq_o       = irq_q;
    assign unused_bits = ^{PADDR_i, PWDATA_i};

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            wr_ch[c] = wr && (ch_sel == 4'(c));
`ifdef APB_TIMER_PRESCALER_EN
            tick[c]  = en_q[c] & (~psc_en_q[c] | (pcnt_q[c] == psc_q[c]));
`else
            tick[c]  = en_q[c];
`endif
            match[c] = tick[c] & (val_q[c] == cmp_q[c]);
        end
    end

    // Per-channel next state; later assignments win: tick, APB write, start, event.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            en_d[c]       = en_q[c];
            irq_en_d[c]   = irq_en_q[c];
            cmp_clr_d[c]  = cmp_clr_q[c];
            one_shot_d[c] = one_shot_q[c];
            pend_d[c]     = pend_q[c];
            val_d[c]      = val_q[c];
            cmp_d[c]      = cmp_q[c];
`ifdef APB_TIMER_PRESCALER_EN
            psc_en_d[c]   = psc_en_q[c];
            psc_d[c]      = psc_q[c];
            pcnt_d[c]     = (en_q[c] & psc_en_q[c] & (pcnt_q[c] != psc_q[c])) ?
                            pcnt_q[c] + 8'd1 : 8'd0;
`endif
            if (tick[c]) begin
                if (match[c]) begin
                    val_d[c] = cmp_clr_q[c] ? '0 : val_q[c] + CNT_WIDTH'(1);
                    if (one_shot_q[c]) en_d[c] = 1'b0;
                end else begin
                    val_d[c] = val_q[c] + CNT_WIDTH'(1);
                end
            end
            if (wr_ch[c]) begin
                unique case (reg_sel)
                    2'd0: begin
                        en_d[c]       = PWDATA_i[0];
                        irq_en_d[c]   = PWDATA_i[1];
                        cmp_clr_d[c]  = PWDATA_i[2];
                        one_shot_d[c] = PWDATA_i[3];
`ifdef APB_TIMER_PRESCALER_EN
                        psc_en_d[c]   = PWDATA_i[4];
                        psc_d[c]      = PWDATA_i[15:8];
`endif
                        // Stopping the channel freezes VAL even if it would have ticked.
                        if (!PWDATA_i[0]) val_d[c] = val_q[c];
                    end
                    2'd1: val_d[c] = PWDATA_i[CNT_WIDTH-1:0];
                    2'd2: cmp_d[c] = PWDATA_i[CNT_WIDTH-1:0];
                    default: if (PWDATA_i[0]) pend_d[c] = 1'b0;
                endcase
            end
            if (match[c]) pend_d[c] = 1'b1;
            if ((!en_q[c] && en_d[c]) || event_i[c]) begin
                val_d[c]  = '0;
`ifdef APB_TIMER_PRESCALER_EN
                pcnt_d[c] = 8'd0;
`endif
            end
            if (event_i[c]) en_d[c] = 1'b1;
        end
    end

    always_comb begin
        PRDATA_o = '0;
        if (access && !PWRITE_i && ch_ok) begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_sel == 4'(c)) begin
                    unique case (reg_sel)
                        2'd0: begin
                            PRDATA_o[3:0] = {one_shot_q[c], cmp_clr_q[c], irq_en_q[c], en_q[c]};
`ifdef APB_TIMER_PRESCALER_EN
                            PRDATA_o[4]    = psc_en_q[c];
                            PRDATA_o[15:8] = psc_q[c];
`endif
                        end
                        2'd1: PRDATA_o = 32'(val_q[c]);
                        2'd2: PRDATA_o = 32'(cmp_q[c]);
                        default: PRDATA_o = {31'd0, pend_q[c]};
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q       <= '0;
            irq_en_q   <= '0;
            cmp_clr_q  <= '0;
            one_shot_q <= '0;
            pend_q     <= '0;
            irq_q      <= '0;
`ifdef APB_TIMER_PRESCALER_EN
            psc_en_q   <= '0;
`endif
            for (int c = 0; c < N_CH; c++) begin
                val_q[c]  <= '0;
                cmp_q[c]  <= '0;
`ifdef APB_TIMER_PRESCALER_EN
                psc_q[c]  <= '0;
                pcnt_q[c] <= '0;
`endif
            end
        end else begin
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            cmp_clr_q  <= cmp_clr_d;
            one_shot_q <= one_shot_d;
            pend_q     <= pend_d;
            irq_q      <= pend_q & irq_en_q;
`ifdef APB_TIMER_PRESCALER_EN
            psc_en_q   <= psc_en_d;
`endif
            for (int c = 0; c < N_CH; c++) begin
                val_q[c]  <= val_d[c];
                cmp_q[c]  <= cmp_d[c];
`ifdef APB_TIMER_PRESCALER_EN
                psc_q[c]  <= psc_d[c];
                pcnt_q[c] <= pcnt_d[c];
`endif
            end
        end
    end

endmodule
